// File: rtl/mem_arbiter_if.sv
// Requester ports plus the memory port of the fetch/load-store memory arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until ack; stall reports an unacknowledged request.
interface mem_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 20
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [WIDTH-1:0]  if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [WIDTH-1:0]  d_wdata;
  logic              d_ack;
  logic [WIDTH-1:0]  d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  logic              stall;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall, busy
  );

  // Core and memory side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port fixed-latency memory between fetch and load/store.
// Latency: request seen in IDLE -> ack MEM_LAT+2 cycles later; one access every MEM_LAT+3 cycles.
// Backpressure: requesters hold req until their ack pulse; stall is high while a request is unacked.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 20,
  parameter int MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         rstn,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic {SRC_FETCH, SRC_DATA} src_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state;
  src_t              src;
  src_t              last;
  src_t              win;
  logic [3:0]        cnt;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WIDTH-1:0]  mem_wdata_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic [WIDTH-1:0]  if_rdata_q;
  logic [WIDTH-1:0]  d_rdata_q;
  logic              busy_q;

  // Round-robin pick: on a tie the requester that did not win last time gets the slot.
  always_comb begin
    win = SRC_FETCH;
    if (bus.d_req && (!bus.if_req || last == SRC_FETCH)) begin
      win = SRC_DATA;
    end
  end

  // Access sequencer: grant in IDLE, strobe the memory in ISSUE, count out the latency, then ack.
  // The read-data register is split per requester so the unselected rdata output stays 0,
  // and both halves are cleared when the ack pulse ends.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      src         <= SRC_FETCH;
      last        <= SRC_FETCH;
      cnt         <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            src      <= win;
            last     <= win;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= ISSUE;
            if (win == SRC_DATA) begin
              mem_addr_q  <= bus.d_addr;
              mem_we_q    <= bus.d_we;
              mem_wdata_q <= bus.d_wdata;
            end else begin
              // Fetches never write, so the write-data register is cleared for them.
              mem_addr_q  <= bus.if_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          cnt      <= CNT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ACK;
            if (src == SRC_FETCH) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end else begin
              // A store returns nothing meaningful, so its ack carries zero data.
              d_ack_q   <= 1'b1;
              d_rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
            end
          end
        end
        ACK: begin
          if_ack_q   <= 1'b0;
          d_ack_q    <= 1'b0;
          if_rdata_q <= '0;
          d_rdata_q  <= '0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall drops in the ack cycle so the core advances on the edge that ends it.
  assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported, fixed-latency memory between the core's instruction fetch path and its load/store path. It sits between the CPU top level and the memory macro. It serialises accesses with a four-state FSM and returns read data with a one-cycle acknowledge pulse. Its combinational `stall` output freezes the PC, LR and register-file write enables while an access is outstanding.

## Interface
- `WIDTH`, 32, data width
- `ADDR_W`, 20, word-address width
- `MEM_LAT`, 2, memory read latency in cycles (legal range 1..15)

- `clk`  in  1  sole clock, rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `if_rdata`  out  WIDTH  fetched word, valid while `if_ack`=1
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  WIDTH  store data
- `d_ack`  out  1  one-cycle completion pulse for data
- `d_rdata`  out  WIDTH  load data, valid while `d_ack`=1
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  WIDTH  memory write data
- `mem_rdata`  in  WIDTH  valid exactly `MEM_LAT` cycles after the `mem_en` cycle
- `stall`  out  1  `(if_req & ~if_ack) | (d_req & ~d_ack)`, combinational
- `busy`  out  1  state != IDLE, registered

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE
  - If no request: stay in IDLE.
  - If requests are pending: choose a winner, latch `src`, address, `we` and wdata into the `mem_*` registers, and go to ISSUE.
- Arbitration is two-way round robin on `last`:
  - If both requesters are pending, grant the one that is not `last`.
  - If only one is pending, grant it.
  - `last` is updated at grant.
  - `last` resets to FETCH, so the first tie goes to data.
- ISSUE: `mem_en`=1 for exactly this cycle. Load `cnt`=MEM_LAT-1 and go to WAIT.
- WAIT: `mem_en`=0.
  - If `cnt`!=0: decrement `cnt`.
  - If `cnt`==0: capture `mem_rdata` into the `rdata` register and go to ACK.
- ACK: pulse the ack of `src` for one cycle, drive `rdata` on the matching `*_rdata`, then go to IDLE.
- Stores follow the identical sequence. The captured rdata is don't-care, and `d_ack` timing is the same as for a load.
- A request still high in the IDLE cycle after its ack is treated as a new request; the core presents the next address on that edge.
- Payload is latched at grant, so requester input changes after grant do not affect the access in flight.
- Protocol violation (`req` dropped before ack): the access still completes and the ack still pulses.
- Only one ack may be high in any cycle.
- `mem_addr`, `mem_we` and `mem_wdata` hold their values from ISSUE until the next grant.
- `*_rdata` outputs are 0 whenever their ack is low.
- Reset (asynchronous, any state, including mid-access):
  - state=IDLE, `cnt`=0, `last`=FETCH
  - all `mem_*` outputs, acks, rdata and `busy` are 0
  - the in-flight access is abandoned and no ack is issued after reset release

## Timing
- Request seen in IDLE at cycle 0:
  - `mem_en` in cycle 1
  - `mem_rdata` sampled at the end of cycle 1+MEM_LAT
  - ack in cycle 2+MEM_LAT
  - IDLE in cycle 3+MEM_LAT
- Request-to-ack latency is MEM_LAT+2 cycles; back-to-back access period is MEM_LAT+3 cycles.
- With MEM_LAT=1, WAIT lasts one cycle. With MEM_LAT=2: `mem_en` in cycle 1, ack in cycle 4.
- `stall` falls combinationally in the ack cycle, so the core's state updates on the edge that ends the ack cycle.
- All outputs except `stall` are registered.

## Test plan
- Single fetch (MEM_LAT=2): `if_req`=1 with `if_addr`=0x00010 in cycle 0; memory returns 0xDEADBEEF.
  - Required: `mem_en`=1 only in cycle 1 with `mem_addr`=0x00010 and `mem_we`=0.
  - Required: `if_ack`=1 with `if_rdata`=0xDEADBEEF only in cycle 4; `stall`=1 in cycles 0–3.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x00100, `d_wdata`=0x12345678.
  - Required: in cycle 1, `mem_we`=1 with that address and data.
  - Required: `d_ack` in cycle 4 and `d_rdata`=0.
- Tie from reset: `if_req` and `d_req` both high from cycle 0.
  - Required: data is granted first (ack in cycle 4).
  - Required: fetch `mem_en` in cycle 6 and `if_ack` in cycle 9; the two acks never overlap.
- Round robin under a continuous tie:
  - Required: grants alternate D, F, D, F over 8 accesses, each 5 cycles apart.
- Reset mid-access: assert `rstn`=0 during WAIT.
  - Required: all outputs are 0 immediately.
  - Required: after release with no requests, no ack ever appears and `busy`=0.
- MEM_LAT=1 back-to-back fetches with `if_req` held high:
  - Required: `if_ack` pulses every 4 cycles, and each pulse carries the data for its own address.
